// File: rtl/reg_to_apb_master.sv
// Register-bus request port to APB master bridge: one valid/ready request -> one SETUP/ACCESS transfer.
// Optional ACCESS timeout abort is compiled in with `define REG_TO_APB_TIMEOUT_EN.
module reg_to_apb_master #(
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    valid_i,
   input  logic                    write_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] wstrb_i,
   output logic                    ready_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    error_o,
   output logic                    psel_o,
   output logic                    penable_o,
   output logic                    pwrite_o,
   output logic [ADDR_WIDTH-1:0]   paddr_o,
   output logic [DATA_WIDTH-1:0]   pwdata_o,
   output logic [DATA_WIDTH/8-1:0] pstrb_o,
   input  logic [DATA_WIDTH-1:0]   prdata_i,
   input  logic                    pready_i,
   input  logic                    pslverr_i
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   if (DATA_WIDTH % 8 != 0) begin : g_dw_check
      $error("reg_to_apb_master: DATA_WIDTH must be a multiple of 8");
   end
   if (TimeoutCycles < 1) begin : g_to_check
      $error("reg_to_apb_master: TimeoutCycles must be >= 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } state_e;

   state_e                r_state;
   logic                  r_psel;
   logic                  r_penable;
   logic                  r_ready;
   logic                  r_error;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_pwrite;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic [STRB_WIDTH-1:0] r_pstrb;
   logic                  w_timeout;

`ifdef REG_TO_APB_TIMEOUT_EN
   localparam int unsigned           CNT_WIDTH = $clog2(TimeoutCycles + 1);
   localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(TimeoutCycles - 1);

   logic [CNT_WIDTH-1:0] r_wait_cnt;

   // The abort fires on the wait cycle whose increment would make the count reach TimeoutCycles.
   assign w_timeout = (r_wait_cnt == CNT_LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wait_cnt <= '0;
      end else if (r_state == ST_SETUP) begin
         r_wait_cnt <= '0;
      end else if (r_state == ST_ACCESS && !pready_i) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // NOTE: state and outputs are updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= ST_IDLE;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_ready   <= 1'b0;
         r_error   <= 1'b0;
         r_rdata   <= '0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_pstrb   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (valid_i) begin
                  r_pwrite <= write_i;
                  r_paddr  <= addr_i;
                  r_pwdata <= write_i ? wdata_i : '0;
                  r_pstrb  <= write_i ? wstrb_i : '0;
                  r_rdata  <= '0;
                  r_error  <= 1'b0;
                  r_psel   <= 1'b1;
                  r_state  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // A slave completing on the timeout cycle still wins over the abort.
               if (pready_i) begin
                  r_error   <= pslverr_i;
                  r_rdata   <= (!r_pwrite && !pslverr_i) ? prdata_i : '0;
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_ready   <= 1'b1;
                  r_state   <= ST_RESP;
               end else if (w_timeout) begin
                  r_error   <= 1'b1;
                  r_rdata   <= '0;
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_ready   <= 1'b1;
                  r_state   <= ST_RESP;
               end
            end
            ST_RESP: begin
               r_ready <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_psel    <= 1'b0;
               r_penable <= 1'b0;
               r_ready   <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready_o   = r_ready;
   assign rdata_o   = r_rdata;
   assign error_o   = r_error;
   assign psel_o    = r_psel;
   assign penable_o = r_penable;
   assign pwrite_o  = r_pwrite;
   assign paddr_o   = r_paddr;
   assign pwdata_o  = r_pwdata;
   assign pstrb_o   = r_pstrb;

endmodule

// File: tb/tb_reg_to_apb_master.sv
// Self-checking bench for reg_to_apb_master: transaction-timing model plus directed literal checks.
// Build with REG_TO_APB_TIMEOUT_EN defined to exercise the ACCESS timeout abort.
module tb_reg_to_apb_master;

   localparam int T_CYC = 4;
`ifdef REG_TO_APB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        valid_i = 1'b0;
   logic        write_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic [3:0]  wstrb_i = '0;
   logic        ready_o;
   logic [31:0] rdata_o;
   logic        error_o;
   logic        psel_o;
   logic        penable_o;
   logic        pwrite_o;
   logic [31:0] paddr_o;
   logic [31:0] pwdata_o;
   logic [3:0]  pstrb_o;
   logic [31:0] prdata_i = '0;
   logic        pready_i = 1'b0;
   logic        pslverr_i = 1'b0;

   reg_to_apb_master #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .TimeoutCycles (T_CYC)
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .valid_i   (valid_i),
      .write_i   (write_i),
      .addr_i    (addr_i),
      .wdata_i   (wdata_i),
      .wstrb_i   (wstrb_i),
      .ready_o   (ready_o),
      .rdata_o   (rdata_o),
      .error_o   (error_o),
      .psel_o    (psel_o),
      .penable_o (penable_o),
      .pwrite_o  (pwrite_o),
      .paddr_o   (paddr_o),
      .pwdata_o  (pwdata_o),
      .pstrb_o   (pstrb_o),
      .prdata_i  (prdata_i),
      .pready_i  (pready_i),
      .pslverr_i (pslverr_i)
   );

   always #5 clk_i = ~clk_i;

   int n_pass = 0;
   int n_chk  = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // Transaction model: a request accepted in cycle t0 has age = cycle - t0.
   // SETUP at age 1, ACCESS at ages 2..2+eff, response pulse at age 3+eff.
   bit          m_active = 1'b0;
   int          m_age = 0;
   int          m_w = 0;
   bit          m_write = 1'b0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_wdata = '0;
   logic [3:0]  m_strb = '0;
   logic [31:0] m_rprdata = '0;
   bit          m_rslverr = 1'b0;
   int          force_w = -1;
   bit          dir_en = 1'b0;
   logic [31:0] dir_prdata = '0;
   bit          dir_slverr = 1'b0;

   function automatic bit m_to();
      return TO_EN && (m_w >= T_CYC);
   endfunction

   function automatic int m_eff();
      return m_to() ? T_CYC - 1 : m_w;
   endfunction

   // Compare process: checks every output each cycle at the falling edge, then advances the model.
   bit e_psel, e_pen, e_rdy;
   initial forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
         m_active = 1'b0; m_age = 0; m_write = 1'b0;
         m_addr = '0; m_wdata = '0; m_strb = '0;
         check("rst_ready",   64'(ready_o),   64'(0));
         check("rst_rdata",   64'(rdata_o),   64'(0));
         check("rst_error",   64'(error_o),   64'(0));
         check("rst_psel",    64'(psel_o),    64'(0));
         check("rst_penable", 64'(penable_o), 64'(0));
         check("rst_pwrite",  64'(pwrite_o),  64'(0));
         check("rst_paddr",   64'(paddr_o),   64'(0));
         check("rst_pwdata",  64'(pwdata_o),  64'(0));
         check("rst_pstrb",   64'(pstrb_o),   64'(0));
      end else begin
         e_psel = m_active && (m_age <= 2 + m_eff());
         e_pen  = m_active && (m_age >= 2) && (m_age <= 2 + m_eff());
         e_rdy  = m_active && (m_age == 3 + m_eff());
         check("psel",    64'(psel_o),    64'(e_psel));
         check("penable", 64'(penable_o), 64'(e_pen));
         check("ready",   64'(ready_o),   64'(e_rdy));
         check("pwrite",  64'(pwrite_o),  64'(m_write));
         check("paddr",   64'(paddr_o),   64'(m_addr));
         check("pwdata",  64'(pwdata_o),  64'(m_wdata));
         check("pstrb",   64'(pstrb_o),   64'(m_strb));
         if (e_rdy) begin
            check("error", 64'(error_o), 64'(m_to() ? 1'b1 : m_rslverr));
            check("rdata", 64'(rdata_o),
                  64'((m_to() || m_write || m_rslverr) ? 32'h0 : m_rprdata));
         end
         if (m_active && !m_to() && m_age == 2 + m_w) begin
            m_rprdata = prdata_i;
            m_rslverr = pslverr_i;
         end
         if (m_active) begin
            if (e_rdy) m_active = 1'b0;
            else m_age++;
         end else if (valid_i) begin
            m_write  = write_i;
            m_addr   = addr_i;
            m_wdata  = write_i ? wdata_i : 32'h0;
            m_strb   = write_i ? wstrb_i : 4'h0;
            m_w      = (force_w >= 0) ? force_w : int'($urandom_range(0, 5));
            m_active = 1'b1;
            m_age    = 1;
         end
      end
   end

   // APB slave: completes after the model's chosen wait count, drives noise everywhere else.
   initial forever begin
      @(posedge clk_i);
      #1;
      prdata_i  = $urandom;
      pslverr_i = 1'($urandom_range(0, 1));
      if (m_active && m_age >= 2 && m_age <= 2 + m_eff())
         pready_i = !m_to() && (m_age == 2 + m_w);
      else
         pready_i = 1'($urandom_range(0, 1));
      if (dir_en && pready_i && m_active && m_age >= 2) begin
         prdata_i  = dir_prdata;
         pslverr_i = dir_slverr;
      end
   end

   task automatic drive(input bit v, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
      @(posedge clk_i);
      #1;
      valid_i = v;
      write_i = wr;
      addr_i  = a;
      wdata_i = d;
      wstrb_i = s;
   endtask

   task automatic idle_cyc();
      drive(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
   endtask

   int  acc_len;
   bit  seen_rdy;

   initial begin
      repeat (3) @(posedge clk_i);
      #3 rst_ni = 1'b1;
      repeat (2) idle_cyc();

      // Zero-wait write.
      force_w = 0;
      drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      for (int c = 1; c <= 4; c++) begin
         idle_cyc();
         @(negedge clk_i);
         case (c)
            1: begin
               check("t1_setup_psel", 64'(psel_o), 64'(1));
               check("t1_setup_pen",  64'(penable_o), 64'(0));
            end
            2: begin
               check("t1_acc_pen",    64'(penable_o), 64'(1));
               check("t1_acc_paddr",  64'(paddr_o), 64'(32'h10));
               check("t1_acc_pwrite", 64'(pwrite_o), 64'(1));
               check("t1_acc_pstrb",  64'(pstrb_o), 64'(4'hF));
               check("t1_acc_pwdata", 64'(pwdata_o), 64'(32'hDEADBEEF));
            end
            3: begin
               check("t1_ready", 64'(ready_o), 64'(1));
               check("t1_error", 64'(error_o), 64'(0));
               check("t1_rdata", 64'(rdata_o), 64'(0));
            end
            default: check("t1_idle_psel", 64'(psel_o), 64'(0));
         endcase
      end

      // Read with three wait states.
      force_w = 3; dir_en = 1'b1; dir_prdata = 32'h0000A5A5; dir_slverr = 1'b0;
      drive(1'b1, 1'b0, 32'h04, 32'hFFFF_FFFF, 4'hF);
      for (int c = 1; c <= 7; c++) begin
         idle_cyc();
         @(negedge clk_i);
         if (c <= 6) check("t2_pstrb", 64'(pstrb_o), 64'(0));
         if (c >= 2 && c <= 5) begin
            check("t2_acc_pen",   64'(penable_o), 64'(1));
            check("t2_acc_paddr", 64'(paddr_o), 64'(32'h04));
         end
         if (c == 5) check("t2_no_early_ready", 64'(ready_o), 64'(0));
         if (c == 6) begin
            check("t2_ready", 64'(ready_o), 64'(1));
            check("t2_rdata", 64'(rdata_o), 64'(32'h0000A5A5));
            check("t2_error", 64'(error_o), 64'(0));
            check("t2_resp_pen", 64'(penable_o), 64'(0));
         end
      end

      // Read completing with a slave error.
      force_w = 1; dir_prdata = 32'h12345678; dir_slverr = 1'b1;
      drive(1'b1, 1'b0, 32'h08, 32'h0, 4'h0);
      for (int c = 1; c <= 5; c++) begin
         idle_cyc();
         @(negedge clk_i);
         if (c == 4) begin
            check("t3_ready", 64'(ready_o), 64'(1));
            check("t3_error", 64'(error_o), 64'(1));
            check("t3_rdata", 64'(rdata_o), 64'(0));
         end
      end
      dir_en = 1'b0;

      // Reset asserted during ACCESS.
      force_w = 5;
      drive(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0);
      idle_cyc();
      idle_cyc();
      @(negedge clk_i);
      check("t4_in_access", 64'(penable_o), 64'(1));
      #2 rst_ni = 1'b0;
      #1;
      check("t4_async_psel", 64'(psel_o), 64'(0));
      check("t4_async_pen",  64'(penable_o), 64'(0));
      @(posedge clk_i);
      @(negedge clk_i);
      #2 rst_ni = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         idle_cyc();
         @(negedge clk_i);
         check("t4_post_rst_ready", 64'(ready_o), 64'(0));
         check("t4_post_rst_psel",  64'(psel_o), 64'(0));
      end

      // valid_i held high across back-to-back transfers.
      force_w = 0;
      for (int c = 0; c <= 8; c++) begin
         drive(1'b1, 1'b1, 32'h20, 32'h11223344, 4'h3);
         @(negedge clk_i);
         case (c)
            1: check("t5_first_setup", 64'(psel_o), 64'(1));
            3: begin
               check("t5_ready1",     64'(ready_o), 64'(1));
               check("t5_resp_psel",  64'(psel_o), 64'(0));
            end
            4: begin
               check("t5_gap_psel",   64'(psel_o), 64'(0));
               check("t5_gap_ready",  64'(ready_o), 64'(0));
            end
            5: begin
               check("t5_second_setup", 64'(psel_o), 64'(1));
               check("t5_second_pen",   64'(penable_o), 64'(0));
            end
            7: check("t5_ready2", 64'(ready_o), 64'(1));
            default: ;
         endcase
      end
      repeat (6) idle_cyc();

      // Slave never ready for a long time: timeout abort, or a long ACCESS without it.
      force_w = 120;
      drive(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
      acc_len  = 0;
      seen_rdy = 1'b0;
      for (int c = 1; c <= 300 && !seen_rdy; c++) begin
         idle_cyc();
         @(negedge clk_i);
         if (penable_o) acc_len++;
         if (ready_o) seen_rdy = 1'b1;
      end
      check("t6_ready_seen", 64'(seen_rdy), 64'(1));
      check("t6_access_len", 64'(acc_len), 64'(TO_EN ? T_CYC : 121));
      repeat (2) idle_cyc();

      // Randomized traffic against the model.
      force_w = -1;
      for (int i = 0; i < 500; i++)
         drive(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
               $urandom, $urandom, 4'($urandom));
      repeat (12) idle_cyc();
      @(negedge clk_i);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
